// File: rtl/seven_seg_mux.sv
// -----------------------------------------------------------------------------
// seven_seg_mux
//
// Drives a two-digit, time-multiplexed 7-segment display from the BCD digit
// pair (zehner = tens, einer = units). The pair is captured into shadow
// registers only at the tens-to-units frame boundary, so a digit can never
// change part-way through a frame. Options: leading-zero blanking of the tens
// digit, whole-display blinking, and a dash for invalid BCD codes.
//
// Parameters:
//   REFRESH_DIV  - clock cycles per digit slot (>= 2)
//   BLINK_FRAMES - frames per blink half-period (>= 1), frame = 2 slots
//
// Ports:
//   clk_i      in   system clock, rising edge
//   rst_i      in   synchronous active-high reset
//   zehner     in   [3:0] tens digit, BCD (10..15 invalid)
//   einer      in   [3:0] units digit, BCD (10..15 invalid)
//   blank_lz_i in   blank the tens digit when the latched tens value is 0
//   blink_i    in   blink the whole display
//   seg_o      out  [6:0] segments {g,f,e,d,c,b,a}, active-high, registered
//   dig_o      out  [1:0] digit enables, bit0 = units, bit1 = tens, registered
// -----------------------------------------------------------------------------
module seven_seg_mux #(
  parameter int REFRESH_DIV  = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] zehner,
  input  logic [3:0] einer,
  input  logic       blank_lz_i,
  input  logic       blink_i,
  output logic [6:0] seg_o,
  output logic [1:0] dig_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt;
  logic             sel;
  logic [FRM_W-1:0] frame_cnt;
  logic             phase_on;
  logic [3:0]       sh_tens;
  logic [3:0]       sh_units;

  logic             slot_end;
  logic             frame_end;
  logic [3:0]       digit;
  logic             show;
  logic             blank_tens;
  logic [6:0]       seg_p0;
  logic [1:0]       dig_p0;

  // BCD to segment pattern {g,f,e,d,c,b,a}; anything above 9 renders a dash.
  function automatic logic [6:0] decode_bcd(input logic [3:0] d);
    case (d)
      4'd0:    decode_bcd = 7'h3F;
      4'd1:    decode_bcd = 7'h06;
      4'd2:    decode_bcd = 7'h5B;
      4'd3:    decode_bcd = 7'h4F;
      4'd4:    decode_bcd = 7'h66;
      4'd5:    decode_bcd = 7'h6D;
      4'd6:    decode_bcd = 7'h7D;
      4'd7:    decode_bcd = 7'h07;
      4'd8:    decode_bcd = 7'h7F;
      4'd9:    decode_bcd = 7'h6F;
      default: decode_bcd = 7'h40;
    endcase
  endfunction

  // Stage p0: combinational display word from the current slot state
  always_comb begin
    slot_end   = (cnt == CNT_MAX);
    frame_end  = slot_end && sel;
    digit      = sel ? sh_tens : sh_units;
    // blink_i low forces the display on immediately, without waiting for
    // the registered phase to be re-forced on the next edge.
    show       = phase_on || !blink_i;
    blank_tens = sel && blank_lz_i && (sh_tens == 4'd0);
    seg_p0     = 7'h00;
    dig_p0     = 2'b00;
    if (show && !blank_tens) begin
      seg_p0 = decode_bcd(digit);
      dig_p0 = sel ? 2'b10 : 2'b01;
    end
  end

  // Stage p1: slot/frame/blink state and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      sel       <= 1'b0;
      frame_cnt <= '0;
      phase_on  <= 1'b1;
      sh_tens   <= 4'd0;
      sh_units  <= 4'd0;
      seg_o     <= 7'h00;
      dig_o     <= 2'b00;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) sel <= ~sel;

      if (frame_end) begin
        sh_tens  <= zehner;
        sh_units <= einer;
      end

      if (!blink_i) begin
        frame_cnt <= '0;
        phase_on  <= 1'b1;
      end else if (frame_end) begin
        if (frame_cnt == FRM_MAX) begin
          frame_cnt <= '0;
          phase_on  <= ~phase_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      seg_o <= seg_p0;
      dig_o <= dig_p0;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
module tb_seven_seg_mux;

  localparam int RD = 4;
  localparam int BF = 2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] zehner;
  logic [3:0] einer;
  logic       blank_lz_i;
  logic       blink_i;
  logic [6:0] seg_o;
  logic [1:0] dig_o;

  int total = 0;
  int bad   = 0;

  // Reference model state: cycles since reset, latched digits, and the number
  // of frame boundaries seen since blink_i was last low.
  int         n = 0;
  int         bcount = 0;
  logic [3:0] m_t = 4'd0;
  logic [3:0] m_u = 4'd0;

  seven_seg_mux #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .zehner     (zehner),
    .einer      (einer),
    .blank_lz_i (blank_lz_i),
    .blink_i    (blink_i),
    .seg_o      (seg_o),
    .dig_o      (dig_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d > 4'd9) return 7'h40;
    return tbl[d];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  // One clock: predict the outputs produced by the coming edge, advance the
  // model, then compare after the falling edge.
  task automatic tick();
    logic [6:0] es;
    logic [1:0] ed;
    logic       sel_m;
    logic       off;
    if (rst_i) begin
      es = 7'h00; ed = 2'b00;
      n = 0; bcount = 0; m_t = 4'd0; m_u = 4'd0;
    end else begin
      sel_m = ((n / RD) % 2) == 1;
      off   = (blink_i && ((bcount / BF) % 2 == 1)) ||
              (sel_m && blank_lz_i && m_t == 4'd0);
      if (off) begin
        es = 7'h00; ed = 2'b00;
      end else begin
        es = seg_of(sel_m ? m_t : m_u);
        ed = sel_m ? 2'b10 : 2'b01;
      end
      if (n % (2 * RD) == 2 * RD - 1) begin
        m_t = zehner;
        m_u = einer;
        if (blink_i) bcount++;
      end
      if (!blink_i) bcount = 0;
      n++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    chk("seg", {1'b0, seg_o}, {1'b0, es});
    chk("dig", {6'd0, dig_o}, {6'd0, ed});
    chk("dig_not_11", {7'd0, dig_o == 2'b11}, 8'd0);
  endtask

  initial begin
    rst_i = 1'b1; zehner = 4'd0; einer = 4'd0; blank_lz_i = 1'b0; blink_i = 1'b0;

    // Reset
    repeat (3) tick();
    chk("reset_seg", {1'b0, seg_o}, 8'h00);
    chk("reset_dig", {6'd0, dig_o}, 8'h00);
    rst_i = 1'b0;
    zehner = 4'd4; einer = 4'd2;
    tick();
    chk("first_seg", {1'b0, seg_o}, 8'h3F);
    chk("first_dig", {6'd0, dig_o}, 8'h01);
    repeat (24) tick();

    // Mid-frame change during the tens slot
    while (((n / RD) % 2) == 0) tick();
    einer = 4'd7;
    repeat (20) tick();

    // Leading-zero blanking
    zehner = 4'd0; einer = 4'd5; blank_lz_i = 1'b1;
    repeat (16) tick();
    blank_lz_i = 1'b0;
    repeat (8) tick();
    einer = 4'd0; blank_lz_i = 1'b1;
    repeat (16) tick();

    // Invalid BCD, with and without blanking
    zehner = 4'd12; einer = 4'd15;
    repeat (16) tick();
    blank_lz_i = 1'b0;
    repeat (8) tick();

    // Blink, release during the off phase, then reset mid-slot
    zehner = 4'd3; einer = 4'd9; blink_i = 1'b1;
    repeat (40) tick();
    while (((bcount / BF) % 2) == 0) tick();
    tick();
    blink_i = 1'b0;
    tick();
    chk("blink_release_dig", {7'd0, dig_o != 2'b00}, 8'd1);
    blink_i = 1'b1;
    repeat (21) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (12) tick();

    // Randomized phase
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) zehner = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) einer  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) zehner = 4'd0;
      if ($urandom_range(0, 15) == 0) blank_lz_i = ~blank_lz_i;
      if ($urandom_range(0, 40) == 0) blink_i = ~blink_i;
      rst_i = ($urandom_range(0, 150) == 0);
      tick();
    end
    rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
